uart_tx_mmio: RTL and testbench

Memory-mapped UART transmitter on the cpu32 data bus, a sibling consumer of `d_addr`/`d_data_w`/`d_data_we` alongside the video RAM and data RAM. CPU stores are queued in a small FIFO and serialized as 8N1 frames on a single `tx` pin for console/debug output. A status word is returned on a registered read port that the board mux selects when the address decodes to this block.

---
 rtl/cpu32_io_pkg.sv | 22 ++
 rtl/sync_fifo.sv | 59 +++++
 rtl/uart_tx_mmio.sv | 154 +++++++++++++++
 tb/tb_uart_tx_mmio.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu32_io_pkg.sv
// Shared definitions for the cpu32 memory-mapped I/O blocks.
// Holds the UART register offsets (word offsets, addr[3:2]), the STATUS
// bit positions and the transmit state enumeration.
package cpu32_io_pkg;

  localparam logic [1:0] UART_TXDATA = 2'd0;
  localparam logic [1:0] UART_STATUS = 2'd1;

  localparam int ST_FULL    = 0;
  localparam int ST_EMPTY   = 1;
  localparam int ST_BUSY    = 2;
  localparam int ST_OVF     = 3;
  localparam int ST_CNT_LSB = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO, single clock, head-of-queue visible on dout.
// Ports:
//   clk, reset_n : clock and asynchronous active-low reset
//   push, din    : write request and data; ignored when full (even if a pop
//                  happens in the same cycle)
//   pop, dout    : read request and current head; ignored when empty
//   full, empty  : occupancy flags
//   count        : number of stored entries, DEPTH_LOG2+1 bits
module sync_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  push,
  input  logic                  pop,
  input  logic [WIDTH-1:0]      din,
  output logic [WIDTH-1:0]      dout,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count
);

  localparam logic [DEPTH_LOG2:0] DEPTH = (DEPTH_LOG2+1)'(2**DEPTH_LOG2);

  logic [WIDTH-1:0]      mem [2**DEPTH_LOG2];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic                  push_ok;
  logic                  pop_ok;

  assign full    = (count == DEPTH);
  assign empty   = (count == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  // Storage holds data only and needs no reset.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter on the cpu32 data bus.
// Stores to TXDATA are queued in a FIFO and shifted out LSB first on tx.
// Ports:
//   clk, reset_n : system clock, asynchronous active-low reset
//   addr, wdata  : CPU data address / write data (only wdata[7:0] used)
//   we           : CPU write strobe
//   rdata        : registered read data (STATUS at offset 1, else 0)
//   tx           : serial line, idle high, registered
//   busy         : frame in progress or FIFO non-empty
module uart_tx_mmio
  import cpu32_io_pkg::*;
#(
  parameter logic [15:0] BASE       = 16'hB000,
  parameter int          DIVISOR    = 434,
  parameter int          DEPTH_LOG2 = 3
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        we,
  output logic [31:0] rdata,
  output logic        tx,
  output logic        busy
);

  localparam logic [15:0] BAUD_RELOAD = 16'(DIVISOR - 1);

  logic                sel;
  logic [1:0]          off;
  logic                push;
  logic                pop;
  logic                full;
  logic                empty;
  logic [DEPTH_LOG2:0] count;
  logic [7:0]          head;
  logic                ovf;
  logic                ovf_clr;
  logic [31:0]         status;
  logic                unused_bits;

  uart_state_t state;
  logic [2:0]  bit_idx;
  logic [15:0] baud;
  logic [7:0]  shift;
  logic        baud_done;

  assign sel         = (addr[31:16] == BASE);
  assign off         = addr[3:2];
  assign push        = sel & we & (off == UART_TXDATA);
  assign ovf_clr     = sel & we & (off == UART_STATUS);
  assign baud_done   = (baud == 16'd0);
  assign busy        = (state != IDLE) | ~empty;
  assign unused_bits = ^{addr[15:4], addr[1:0], wdata[31:8]};

  // Pop either from idle or at stop-bit expiry, so back-to-back frames
  // run with no idle cycle between them.
  assign pop = ~empty & ((state == IDLE) | ((state == STOP) & baud_done));

  sync_fifo #(
    .WIDTH      (8),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .pop     (pop),
    .din     (wdata[7:0]),
    .dout    (head),
    .full    (full),
    .empty   (empty),
    .count   (count)
  );

  always_comb begin
    status                   = '0;
    status[ST_FULL]          = full;
    status[ST_EMPTY]         = empty;
    status[ST_BUSY]          = busy;
    status[ST_OVF]           = ovf;
    status[ST_CNT_LSB +: 4]  = 4'(count);
  end

  // Bus side: sticky overflow (clear wins) and registered read data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ovf   <= 1'b0;
      rdata <= '0;
    end else begin
      if (ovf_clr)          ovf <= 1'b0;
      else if (push & full) ovf <= 1'b1;
      rdata <= (sel && off == UART_STATUS) ? status : 32'd0;
    end
  end

  // Shift register carries data only; loaded on pop, shifted per data bit.
  always_ff @(posedge clk) begin
    if (pop)                               shift <= head;
    else if (state == DATA && baud_done)   shift <= shift >> 1;
  end

  // Transmit FSM. tx is registered from the current state, so the line
  // follows the state by one cycle while each bit still lasts DIVISOR cycles.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      bit_idx <= 3'd0;
      baud    <= 16'd0;
      tx      <= 1'b1;
    end else begin
      case (state)
        START:   tx <= 1'b0;
        DATA:    tx <= shift[0];
        default: tx <= 1'b1;
      endcase
      case (state)
        IDLE: begin
          if (pop) begin
            baud  <= BAUD_RELOAD;
            state <= START;
          end
        end
        START: begin
          if (baud_done) begin
            baud    <= BAUD_RELOAD;
            bit_idx <= 3'd0;
            state   <= DATA;
          end else begin
            baud <= baud - 16'd1;
          end
        end
        DATA: begin
          if (baud_done) begin
            baud    <= BAUD_RELOAD;
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) state <= STOP;
          end else begin
            baud <= baud - 16'd1;
          end
        end
        STOP: begin
          if (baud_done) begin
            baud  <= BAUD_RELOAD;
            state <= pop ? START : IDLE;
          end else begin
            baud <= baud - 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Self-checking bench for uart_tx_mmio (DIVISOR=4, DEPTH_LOG2=3).
// A cycle-level behavioural model (byte queue plus a frame countdown) predicts
// tx, busy and rdata; a compare process checks them on every falling edge.
module tb_uart_tx_mmio;

  localparam int D   = 4;
  localparam int FR  = 10 * D;
  localparam int DEP = 8;
  localparam logic [31:0] A_TX = 32'hB000_0000;
  localparam logic [31:0] A_ST = 32'hB000_0004;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        we = 1'b0;
  logic [31:0] rdata;
  logic        tx;
  logic        busy;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  uart_tx_mmio #(
    .BASE       (16'hB000),
    .DIVISOR    (D),
    .DEPTH_LOG2 (3)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .addr    (addr),
    .wdata   (wdata),
    .we      (we),
    .rdata   (rdata),
    .tx      (tx),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  logic [7:0]  mq[$];
  int          m_r = 0;        // cycles left in the current frame, 0 = idle
  logic [7:0]  m_cur = '0;
  logic        m_ovf = 1'b0;
  logic        m_tx = 1'b1;
  logic [31:0] m_rd = '0;

  function automatic logic line_bit(int r, logic [7:0] b);
    int seg;
    if (r == 0) return 1'b1;
    seg = (FR - r) / D;
    if (seg == 0) return 1'b0;
    if (seg <= 8) return b[seg-1];
    return 1'b1;
  endfunction

  function automatic logic m_busy();
    return (m_r > 0) || (mq.size() > 0);
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mq.delete();
      m_r   = 0;
      m_ovf = 1'b0;
      m_tx  = 1'b1;
      m_rd  = '0;
    end else begin : step
      int   cnt;
      logic bsy, sel, do_pop, set_ovf;
      cnt     = mq.size();
      bsy     = m_busy();
      sel     = (addr[31:16] == 16'hB000);
      set_ovf = 1'b0;
      m_tx    = line_bit(m_r, m_cur);
      if (sel && addr[3:2] == 2'd1)
        m_rd = {24'd0, 4'(cnt), m_ovf, bsy, (cnt == 0), (cnt == DEP)};
      else
        m_rd = '0;
      do_pop = (m_r <= 1) && (cnt > 0);
      if (sel && we && addr[3:2] == 2'd0) begin
        if (cnt < DEP) mq.push_back(wdata[7:0]);
        else           set_ovf = 1'b1;
      end
      if (do_pop) begin
        m_cur = mq.pop_front();
        m_r   = FR;
      end else if (m_r > 0) begin
        m_r = m_r - 1;
      end
      if (set_ovf) m_ovf = 1'b1;
      if (sel && we && addr[3:2] == 2'd1) m_ovf = 1'b0;
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("tx", {31'd0, tx}, {31'd0, m_tx});
      chk("busy", {31'd0, busy}, {31'd0, m_busy()});
      chk("rdata", rdata, m_rd);
    end
  end

  // ---------------- bus tasks (called at a falling edge) ----------------
  task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
    addr = a; wdata = d; we = 1'b1;
    @(negedge clk);
  endtask

  task automatic bus_rd(input logic [31:0] a);
    addr = a; wdata = '0; we = 1'b0;
    @(negedge clk);
  endtask

  task automatic idle_now();
    addr = '0; wdata = '0; we = 1'b0;
  endtask

  task automatic wait_idle(input int bound);
    int n = 0;
    idle_now();
    while (busy && n < bound) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", {31'd0, busy}, 32'd0);
    @(negedge clk);
  endtask

  logic cap_tx [200];
  logic cap_busy [200];

  task automatic capture(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cap_tx[i]   = tx;
      cap_busy[i] = busy;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] exp55;
    #1 reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    chk_en  = 1'b1;
    chk("reset_tx", {31'd0, tx}, 32'd1);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_rdata", rdata, 32'd0);

    // Single byte 0x55: start, LSB-first data, stop, 4 cycles each.
    bus_wr(A_TX, 32'h55);
    idle_now();
    @(negedge clk);
    chk("t1_pre_start", {31'd0, tx}, 32'd1);
    capture(FR);
    exp55 = 8'h55;
    for (int b = 0; b < 10; b++) begin
      logic e;
      e = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : exp55[b-1];
      chk($sformatf("t1_bit%0d", b), {31'd0, cap_tx[b*D + 1]}, {31'd0, e});
    end
    chk("t1_busy_last", {31'd0, cap_busy[FR-2]}, 32'd1);
    chk("t1_busy_drop", {31'd0, cap_busy[FR-1]}, 32'd0);
    wait_idle(100);

    // Back-to-back 0x00, 0xFF.
    bus_wr(A_TX, 32'h00);
    bus_wr(A_TX, 32'hFF);
    bus_rd(A_ST);
    chk("t2_status_cnt1", rdata, 32'h14);
    idle_now();
    capture(2*FR - 1);
    chk("t2_data0", {31'd0, cap_tx[20]}, 32'd0);
    chk("t2_stop1", {31'd0, cap_tx[FR-2]}, 32'd1);
    chk("t2_start2", {31'd0, cap_tx[FR-1]}, 32'd0);
    chk("t2_data1", {31'd0, cap_tx[FR+20]}, 32'd1);
    chk("t2_busy_hold", {31'd0, cap_busy[2*FR-3]}, 32'd1);
    chk("t2_busy_drop", {31'd0, cap_busy[2*FR-2]}, 32'd0);
    wait_idle(100);

    // Overflow: ten writes, nine accepted.
    for (int i = 0; i < 10; i++) bus_wr(A_TX, 32'(8'hA0 + i));
    bus_rd(A_ST);
    chk("t3_status_ovf", rdata, 32'h8D);
    bus_wr(A_ST, 32'h0);
    bus_rd(A_ST);
    chk("t3_status_clr", rdata, 32'h85);
    wait_idle(12 * FR);

    // Read latency and decode.
    bus_rd(A_ST);
    chk("t4_status_idle", rdata, 32'h2);
    bus_rd(32'hA000_0000);
    chk("t4_unsel", rdata, 32'h0);
    bus_rd(A_ST);
    bus_rd(32'hB000_0008);
    chk("t4_off2", rdata, 32'h0);
    bus_wr(32'hB000_000C, 32'h41);
    idle_now();
    @(negedge clk);
    chk("t4_off3_ignored", {31'd0, busy}, 32'd0);

    // Reset in the middle of data bit 3.
    bus_wr(A_TX, 32'h3C);
    idle_now();
    repeat (18) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("t5_rst_tx", {31'd0, tx}, 32'd1);
    chk("t5_rst_busy", {31'd0, busy}, 32'd0);
    chk("t5_rst_rdata", rdata, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    bus_rd(A_ST);
    chk("t5_status_empty", rdata, 32'h2);
    bus_wr(A_TX, 32'hC3);
    wait_idle(100);

    // Randomized bus traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      int sel_r;
      sel_r = $urandom_range(0, 199);
      if (sel_r < 6) begin
        bus_wr({16'hB000, 12'($urandom), 2'd0, 2'($urandom)}, $urandom);
      end else if (sel_r < 16) begin
        bus_rd({16'hB000, 12'($urandom), 2'($urandom), 2'($urandom)});
      end else if (sel_r < 19) begin
        bus_wr({16'hB000, 12'($urandom), 2'($urandom), 2'($urandom)}, $urandom);
      end else if (sel_r < 25) begin
        logic [15:0] hi;
        hi = 16'($urandom);
        if (hi == 16'hB000) hi = 16'h0000;
        addr = {hi, 16'($urandom)}; wdata = $urandom; we = 1'($urandom);
        @(negedge clk);
      end else if (sel_r == 199) begin
        for (int k = 0; k < 11; k++) bus_wr(A_TX, $urandom);
      end else begin
        idle_now();
        @(negedge clk);
      end
    end
    wait_idle(12 * FR);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
